// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART receiver slice.
//   rx_state_t    - receiver FSM states
//   PARITY_*      - parity mode encodings for the PARITY_MODE parameter
//   clks_per_bit  - system clocks per serial bit
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_rx_core_if.sv
// uart_rx_core_if: received-word output channel of uart_rx_core.
//   out_data    - received word (DATA_BITS wide)
//   out_valid   - a word is held in out_data
//   out_ready   - consumer accepts the held word
//   parity_err  - parity mismatch on the held word
//   frame_err   - a stop bit of the held word sampled low
//   overrun_err - the held word overwrote an unread word
// master: the receiver; slave: the consumer.
interface uart_rx_core_if #(
  parameter int DATA_BITS = 8
);

  logic [DATA_BITS-1:0] out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic                 parity_err;
  logic                 frame_err;
  logic                 overrun_err;

  modport master (
    output out_data, out_valid, parity_err, frame_err, overrun_err,
    input  out_ready
  );

  modport slave (
    input  out_data, out_valid, parity_err, frame_err, overrun_err,
    output out_ready
  );

endinterface

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: brings the asynchronous rx line into the clock domain.
//   clk, rst - system clock, synchronous active-high reset
//   i_rx     - asynchronous serial line (idle high)
//   o_rx_s   - synchronised line (2-FF)
//   o_rx_p   - o_rx_s delayed by one cycle, for start-edge detection
//   o_bit    - bit value seen by the sampler
// Macro UART_RX_MAJORITY_EN: o_bit is the majority of o_rx_s over the
// current and two preceding cycles; otherwise o_bit is o_rx_s.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic i_rx,
  output logic o_rx_s,
  output logic o_rx_p,
  output logic o_bit
);

  logic r_meta;
  logic r_rx_s;
  logic r_rx_p;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= 1'b1;
      r_rx_s <= 1'b1;
      r_rx_p <= 1'b1;
    end else begin
      r_meta <= i_rx;
      r_rx_s <= r_meta;
      r_rx_p <= r_rx_s;
    end
  end

  assign o_rx_s = r_rx_s;
  assign o_rx_p = r_rx_p;

`ifdef UART_RX_MAJORITY_EN
  // r_rx_p already holds the previous rx_s; one more stage gives the third vote.
  logic r_rx_h2;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_h2 <= 1'b1;
    end else begin
      r_rx_h2 <= r_rx_p;
    end
  end

  assign o_bit = (r_rx_s & r_rx_p) | (r_rx_s & r_rx_h2) | (r_rx_p & r_rx_h2);
`else
  assign o_bit = r_rx_s;
`endif

endmodule

// File: rtl/uart_rx_core.sv
// uart_rx_core: system-clocked UART receiver with mid-bit sampling,
// configurable data width, parity mode and stop-bit count.
//   clk, rst - system clock, synchronous active-high reset
//   rx       - asynchronous serial line (idle high)
//   bus      - received-word channel (uart_rx_core_if.master)
//   busy     - receiver FSM is not idle
// Macro UART_RX_MAJORITY_EN (in uart_rx_sync): 3-sample majority bit voting.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLK_FREQ    = 24000000,
  parameter int BAUD_RATE   = 3000000,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = PARITY_EVEN,
  parameter int STOP_BITS   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx,
  uart_rx_core_if.master   bus,
  output logic             busy
);

  localparam int C     = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int CNT_W = $clog2(C);
  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  logic                 w_rx_s;
  logic                 w_rx_p;
  logic                 w_bit;

  rx_state_t            r_state;
  rx_state_t            w_state_nxt;
  logic [CNT_W-1:0]     r_cnt;
  logic                 w_tick;
  logic                 w_start;
  logic                 w_commit;
  logic [IDX_W-1:0]     r_bit_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par_err;
  logic                 r_frm_err;
  logic                 r_stop_idx;
  logic                 w_par_calc;
  logic                 w_par_err;
  logic                 w_frm_final;

  logic [DATA_BITS-1:0] r_out_data;
  logic                 r_out_valid;
  logic                 r_out_perr;
  logic                 r_out_ferr;
  logic                 r_out_ovr;

  uart_rx_sync u_sync (
    .clk    (clk),
    .rst    (rst),
    .i_rx   (rx),
    .o_rx_s (w_rx_s),
    .o_rx_p (w_rx_p),
    .o_bit  (w_bit)
  );

  assign w_tick      = (r_state != ST_IDLE) && (r_cnt == '0);
  assign w_par_calc  = (^r_shift) ^ w_bit;
  assign w_par_err   = (PARITY_MODE == PARITY_ODD) ? ~w_par_calc : w_par_calc;
  // Last stop sample is folded in directly since commit happens on that tick.
  assign w_frm_final = r_frm_err | ~w_bit;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_commit    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_rx_p && !w_rx_s) begin
          w_start     = 1'b1;
          w_state_nxt = ST_START;
        end
      end
      ST_START: begin
        if (w_tick) begin
          w_state_nxt = w_bit ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_tick && (r_bit_idx == IDX_W'(DATA_BITS - 1))) begin
          w_state_nxt = (PARITY_MODE == PARITY_NONE) ? ST_STOP : ST_PARITY;
        end
      end
      ST_PARITY: begin
        if (w_tick) begin
          w_state_nxt = ST_STOP;
        end
      end
      ST_STOP: begin
        if (w_tick && (r_stop_idx == 1'(STOP_BITS - 1))) begin
          w_commit    = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_par_err  <= 1'b0;
      r_frm_err  <= 1'b0;
      r_stop_idx <= 1'b0;
    end else begin
      if (w_start) begin
        r_cnt <= CNT_W'(C / 2 - 1);
      end else if (r_state != ST_IDLE) begin
        r_cnt <= w_tick ? CNT_W'(C - 1) : r_cnt - CNT_W'(1);
      end

      if (w_tick) begin
        unique case (r_state)
          ST_START: begin
            r_bit_idx  <= '0;
            r_par_err  <= 1'b0;
            r_frm_err  <= 1'b0;
            r_stop_idx <= 1'b0;
          end
          ST_DATA: begin
            r_shift[r_bit_idx] <= w_bit;
            r_bit_idx          <= r_bit_idx + IDX_W'(1);
          end
          ST_PARITY: r_par_err <= w_par_err;
          ST_STOP: begin
            if (!w_bit) begin
              r_frm_err <= 1'b1;
            end
            r_stop_idx <= r_stop_idx + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // Commit takes priority over a same-cycle transfer: the old word leaves,
  // the new one loads, and overrun is raised only if nobody took the old word.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_perr  <= 1'b0;
      r_out_ferr  <= 1'b0;
      r_out_ovr   <= 1'b0;
    end else if (w_commit) begin
      r_out_data  <= r_shift;
      r_out_valid <= 1'b1;
      r_out_perr  <= r_par_err;
      r_out_ferr  <= w_frm_final;
      r_out_ovr   <= r_out_valid & ~bus.out_ready;
    end else if (r_out_valid && bus.out_ready) begin
      r_out_valid <= 1'b0;
      r_out_perr  <= 1'b0;
      r_out_ferr  <= 1'b0;
      r_out_ovr   <= 1'b0;
    end
  end

  assign bus.out_data    = r_out_data;
  assign bus.out_valid   = r_out_valid;
  assign bus.parity_err  = r_out_perr;
  assign bus.frame_err   = r_out_ferr;
  assign bus.overrun_err = r_out_ovr;
  assign busy            = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: three receivers (8N1, 8E1, 7O2) at 8 clocks per bit,
// driven by directed tables, corner-case sequences and random frames
// checked against a frame-level model.
module tb_uart_rx_core;

  localparam int C = 8;
  localparam int NB [3] = '{8, 8, 7};
  localparam int PM [3] = '{0, 1, 2};
  localparam int SB [3] = '{1, 1, 2};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       rx_l    [3];
  logic       rdy     [3];
  logic [8:0] o_data  [3];
  logic       o_valid [3];
  logic       o_perr  [3];
  logic       o_ferr  [3];
  logic       o_ovr   [3];
  logic       o_busy  [3];

  uart_rx_core_if #(.DATA_BITS(8)) if0 ();
  uart_rx_core_if #(.DATA_BITS(8)) if1 ();
  uart_rx_core_if #(.DATA_BITS(7)) if2 ();

  uart_rx_core #(.CLK_FREQ(24000000), .BAUD_RATE(3000000), .DATA_BITS(8),
                 .PARITY_MODE(0), .STOP_BITS(1))
    dut0 (.clk(clk), .rst(rst), .rx(rx_l[0]), .bus(if0), .busy(o_busy[0]));
  uart_rx_core #(.CLK_FREQ(24000000), .BAUD_RATE(3000000), .DATA_BITS(8),
                 .PARITY_MODE(1), .STOP_BITS(1))
    dut1 (.clk(clk), .rst(rst), .rx(rx_l[1]), .bus(if1), .busy(o_busy[1]));
  uart_rx_core #(.CLK_FREQ(24000000), .BAUD_RATE(3000000), .DATA_BITS(7),
                 .PARITY_MODE(2), .STOP_BITS(2))
    dut2 (.clk(clk), .rst(rst), .rx(rx_l[2]), .bus(if2), .busy(o_busy[2]));

  assign if0.out_ready = rdy[0];
  assign if1.out_ready = rdy[1];
  assign if2.out_ready = rdy[2];
  assign o_data[0]  = {1'b0, if0.out_data};
  assign o_data[1]  = {1'b0, if1.out_data};
  assign o_data[2]  = {2'b00, if2.out_data};
  assign o_valid[0] = if0.out_valid;
  assign o_valid[1] = if1.out_valid;
  assign o_valid[2] = if2.out_valid;
  assign o_perr[0]  = if0.parity_err;
  assign o_perr[1]  = if1.parity_err;
  assign o_perr[2]  = if2.parity_err;
  assign o_ferr[0]  = if0.frame_err;
  assign o_ferr[1]  = if1.frame_err;
  assign o_ferr[2]  = if2.frame_err;
  assign o_ovr[0]   = if0.overrun_err;
  assign o_ovr[1]   = if1.overrun_err;
  assign o_ovr[2]   = if2.overrun_err;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Model: parity bit a correct transmitter would send, and the error flag
  // implied by the total count of ones in data + received parity bit.
  function automatic int par_bit(input int k, input int data);
    int ones;
    ones = $countones(data & ((1 << NB[k]) - 1));
    return (PM[k] == 1) ? (ones % 2) : (1 - ones % 2);
  endfunction

  function automatic int perr_of(input int k, input int data, input int pbit);
    int total;
    if (PM[k] == 0) return 0;
    total = $countones(data & ((1 << NB[k]) - 1)) + pbit;
    return (PM[k] == 1) ? (total % 2) : (1 - total % 2);
  endfunction

  function automatic int latency(input int k);
    return 2 + C / 2 + C * (NB[k] + ((PM[k] != 0) ? 1 : 0) + SB[k]);
  endfunction

  // Drives one frame, one bit per C cycles; cycle e of the frame is clock
  // edge e. Reports the first edge after which out_valid / busy was high.
  // glitch: frame bit index whose mid-cycle is inverted (-1: none).
  // ack_e : edge at which out_ready is pulsed (-1: leave out_ready alone).
  task automatic send(input int k, input int data, input int pforce,
                      input int smask, input int glitch, input int ack_e,
                      output int t_valid, output int t_busy);
    bit b[$];
    int e;
    int pb;
    b.push_back(1'b0);
    for (int i = 0; i < NB[k]; i++) b.push_back(1'((data >> i) & 1));
    if (PM[k] != 0) begin
      pb = (pforce >= 0) ? pforce : par_bit(k, data);
      b.push_back(1'(pb));
    end
    for (int s = 0; s < SB[k]; s++) b.push_back(1'(~((smask >> s) & 1)));
    t_valid = -1;
    t_busy  = -1;
    e = 0;
    for (int i = 0; i < b.size(); i++) begin
      for (int j = 0; j < C; j++) begin
        @(negedge clk);
        if (e > 0) begin
          if (o_valid[k] && t_valid < 0) t_valid = e - 1;
          if (o_busy[k] && t_busy < 0) t_busy = e - 1;
        end
        rx_l[k] = b[i] ^ ((glitch == i) && (j == C / 2));
        if (ack_e >= 0) rdy[k] = (e == ack_e);
        e++;
      end
    end
  endtask

  task automatic idle(input int k, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rx_l[k] = 1'b1;
    end
  endtask

  task automatic ack(input int k, input string name);
    @(negedge clk);
    rdy[k] = 1'b1;
    @(negedge clk);
    rdy[k] = 1'b0;
    chk({name, "_ack_valid"}, o_valid[k], 0);
    chk({name, "_ack_ovr"}, o_ovr[k], 0);
  endtask

  task automatic chk_word(input int k, input string name, input int data,
                          input int perr, input int ferr, input int ovr);
    chk({name, "_valid"}, o_valid[k], 1);
    chk({name, "_data"}, int'(o_data[k]), data);
    chk({name, "_perr"}, o_perr[k], perr);
    chk({name, "_ferr"}, o_ferr[k], ferr);
    chk({name, "_ovr"}, o_ovr[k], ovr);
  endtask

  typedef struct {
    int k;
    int data;
    int pforce;
    int smask;
    int edata;
    int eperr;
    int eferr;
  } vec_t;

  typedef struct {
    int data;
    int perr;
    int ferr;
  } exp_t;

  exp_t sbq [3][$];
  logic mon_on = 1'b0;

  // Random phase: out_ready is held high, so every word must transfer with
  // no overrun, in the order the frames were sent.
  always @(negedge clk) begin
    if (mon_on) begin
      for (int k = 0; k < 3; k++) begin
        if (o_valid[k] && rdy[k]) begin
          if (sbq[k].size() == 0) begin
            chk($sformatf("rand%0d_unexpected_word", k), 1, 0);
          end else begin
            exp_t ex;
            ex = sbq[k].pop_front();
            chk($sformatf("rand%0d_data", k), int'(o_data[k]), ex.data);
            chk($sformatf("rand%0d_perr", k), o_perr[k], ex.perr);
            chk($sformatf("rand%0d_ferr", k), o_ferr[k], ex.ferr);
            chk($sformatf("rand%0d_ovr", k), o_ovr[k], 0);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl [9];
    int   tv, tb;
    int   busy_seen, valid_seen;

    tbl[0] = '{0, 'hA5, -1, 0, 'hA5, 0, 0};
    tbl[1] = '{1, 'h07,  0, 0, 'h07, 1, 0};
    tbl[2] = '{1, 'h07,  1, 0, 'h07, 0, 0};
    tbl[3] = '{2, 'h55, -1, 0, 'h55, 0, 0};
    tbl[4] = '{2, 'h55,  0, 0, 'h55, 1, 0};
    tbl[5] = '{2, 'h2A, -1, 2, 'h2A, 0, 1};
    tbl[6] = '{1, 'h3C, -1, 1, 'h3C, 0, 1};
    tbl[7] = '{0, 'hFF, -1, 0, 'hFF, 0, 0};
    tbl[8] = '{2, 'h7F,  1, 0, 'h7F, 1, 0};

    for (int k = 0; k < 3; k++) begin
      rx_l[k] = 1'b1;
      rdy[k]  = 1'b0;
    end
    rst = 1'b1;
    repeat (4) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("reset%0d_valid", k), o_valid[k], 0);
      chk($sformatf("reset%0d_data", k), int'(o_data[k]), 0);
      chk($sformatf("reset%0d_perr", k), o_perr[k], 0);
      chk($sformatf("reset%0d_ferr", k), o_ferr[k], 0);
      chk($sformatf("reset%0d_ovr", k), o_ovr[k], 0);
      chk($sformatf("reset%0d_busy", k), o_busy[k], 0);
    end
    rst = 1'b0;
    idle(0, 4);

    // Directed table
    for (int i = 0; i < 9; i++) begin
      send(tbl[i].k, tbl[i].data, tbl[i].pforce, tbl[i].smask, -1, -1, tv, tb);
      idle(tbl[i].k, 4);
      chk($sformatf("tbl%0d_latency", i), tv, latency(tbl[i].k));
      chk($sformatf("tbl%0d_busy_rise", i), tb, 2);
      chk_word(tbl[i].k, $sformatf("tbl%0d", i), tbl[i].edata, tbl[i].eperr,
               tbl[i].eferr, 0);
      ack(tbl[i].k, $sformatf("tbl%0d", i));
    end

    // Break: low stop bit, line held low for 20 bit times
    send(0, 'h00, -1, 1, -1, -1, tv, tb);
    for (int i = 0; i < 20 * C; i++) begin
      @(negedge clk);
      rx_l[0] = 1'b0;
    end
    chk_word(0, "break", 'h00, 0, 1, 0);
    chk("break_busy", o_busy[0], 0);
    ack(0, "break");
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      rx_l[0] = 1'b0;
    end
    chk("break_no_new_word", o_valid[0], 0);
    idle(0, 4);
    send(0, 'h5A, -1, 0, -1, -1, tv, tb);
    idle(0, 3);
    chk_word(0, "after_break", 'h5A, 0, 0, 0);
    ack(0, "after_break");

    // False start: 2 low cycles
    busy_seen  = 0;
    valid_seen = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (o_busy[0]) busy_seen = 1;
      if (o_valid[0]) valid_seen = 1;
      rx_l[0] = (i < 2) ? 1'b0 : 1'b1;
    end
    chk("false_start_busy_pulse", busy_seen, 1);
    chk("false_start_no_valid", valid_seen, 0);
    chk("false_start_busy_end", o_busy[0], 0);

    // Overrun: two back-to-back frames with out_ready low
    send(1, 'h11, -1, 0, -1, -1, tv, tb);
    send(1, 'h22, -1, 0, -1, -1, tv, tb);
    idle(1, 4);
    chk_word(1, "overrun", 'h22, 0, 0, 1);
    ack(1, "overrun");

    // Commit in the same cycle as a transfer of the held word
    send(0, 'h11, -1, 0, -1, -1, tv, tb);
    send(0, 'h22, -1, 0, -1, latency(0), tv, tb);
    idle(0, 2);
    chk_word(0, "commit_xfer", 'h22, 0, 0, 0);
    ack(0, "commit_xfer");

    // Reset in the middle of the data bits
    for (int i = 0; i < C + 20; i++) begin
      @(negedge clk);
      rx_l[0] = 1'b0;
    end
    chk("midrst_busy_before", o_busy[0], 1);
    rst = 1'b1;
    rx_l[0] = 1'b1;
    repeat (2) @(negedge clk);
    chk("midrst_busy", o_busy[0], 0);
    chk("midrst_valid", o_valid[0], 0);
    chk("midrst_data", int'(o_data[0]), 0);
    rst = 1'b0;
    idle(0, 120);
    chk("midrst_no_commit", o_valid[0], 0);
    send(0, 'h3C, -1, 0, -1, -1, tv, tb);
    idle(0, 3);
    chk("midrst_latency", tv, latency(0));
    chk_word(0, "after_rst", 'h3C, 0, 0, 0);
    ack(0, "after_rst");

`ifdef UART_RX_MAJORITY_EN
    // Single-cycle glitches at the sample point are outvoted
    send(0, 'h00, -1, 0, 3, -1, tv, tb);
    idle(0, 3);
    chk_word(0, "glitch_hi", 'h00, 0, 0, 0);
    ack(0, "glitch_hi");
    send(0, 'hFF, -1, 0, 5, -1, tv, tb);
    idle(0, 3);
    chk_word(0, "glitch_lo", 'hFF, 0, 0, 0);
    ack(0, "glitch_lo");
`endif

    // Random frames, back-to-back where the gap is 0
    for (int k = 0; k < 3; k++) rdy[k] = 1'b1;
    mon_on = 1'b1;
    for (int r = 0; r < 30; r++) begin
      int   k, data, pb, pforce, smask, gap;
      exp_t ex;
      k      = int'($urandom_range(0, 2));
      data   = int'($urandom) & ((1 << NB[k]) - 1);
      pb     = par_bit(k, data);
      pforce = ($urandom_range(0, 3) == 0) ? (1 - pb) : -1;
      smask  = ($urandom_range(0, 4) == 0) ?
               int'($urandom_range(1, (1 << SB[k]) - 1)) : 0;
      ex.data = data;
      ex.perr = perr_of(k, data, (pforce >= 0) ? pforce : pb);
      ex.ferr = (smask != 0) ? 1 : 0;
      sbq[k].push_back(ex);
      send(k, data, pforce, smask, -1, -1, tv, tb);
      gap = (smask != 0) ? int'($urandom_range(2, 4)) : int'($urandom_range(0, 3));
      idle(k, gap);
    end
    for (int i = 0; i < 200; i++) begin
      if (sbq[0].size() + sbq[1].size() + sbq[2].size() == 0) break;
      @(negedge clk);
    end
    chk("rand_all_words_received", sbq[0].size() + sbq[1].size() + sbq[2].size(), 0);
    mon_on = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
